move_scheduler: RTL and testbench

MOVE_SCHEDULER -- requirements
Module: move_scheduler

---
 rtl/game2048_pkg.sv | 35 +++
 rtl/move_fifo.sv | 73 +++++++
 rtl/move_scheduler.sv | 156 +++++++++++++++
 tb/tb_move_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game2048_pkg.sv
// Shared definitions for the 2048 game control slice.
// Holds the direction encoding used on the command bus to the game core,
// the move scheduler FSM state type, and a small helper that picks one
// direction out of a set of simultaneous button presses.
package game2048_pkg;

   // Direction codes carried on cmd_dir; zero means no command.
   localparam logic [2:0] DIR_NONE  = 3'd0;
   localparam logic [2:0] DIR_UP    = 3'd1;
   localparam logic [2:0] DIR_DOWN  = 3'd2;
   localparam logic [2:0] DIR_LEFT  = 3'd3;
   localparam logic [2:0] DIR_RIGHT = 3'd4;

   // Scheduler states: IDLE waits for work, ISSUE offers the queue head to
   // the core, WAIT waits for the core to finish, HALT is the end of game.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_HALT  = 2'd3
   } sched_state_t;

   // Presses are packed {up, down, left, right}; the highest bit wins so
   // up beats down beats left beats right when several arrive together.
   function automatic logic [2:0] pickDir(input logic [3:0] presses);
      logic [2:0] dir;
      dir = DIR_NONE;
      if (presses[3])      dir = DIR_UP;
      else if (presses[2]) dir = DIR_DOWN;
      else if (presses[1]) dir = DIR_LEFT;
      else if (presses[0]) dir = DIR_RIGHT;
      return dir;
   endfunction

endpackage

// File: rtl/move_fifo.sv
// Small circular queue of pending move directions.
// Ports:
//   i_clk     - clock, rising edge
//   i_rst_n   - synchronous active-low reset, empties the queue
//   i_push    - write i_data at the tail (taken when not full, or when a pop
//               happens in the same cycle)
//   i_pop     - discard the head entry (ignored when empty)
//   i_flush   - empty the queue; overrides push and pop
//   i_data    - 3-bit direction to enqueue
//   o_data    - 3-bit direction at the head
//   o_full    - queue holds DEPTH entries
//   o_empty   - queue holds no entries
//   o_level   - current occupancy, 0..DEPTH
module move_fifo
   import game2048_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_push,
   input  logic       i_pop,
   input  logic       i_flush,
   input  logic [2:0] i_data,
   output logic [2:0] o_data,
   output logic       o_full,
   output logic       o_empty,
   output logic [3:0] o_level
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [2:0]    r_mem [DEPTH];
   logic [AW-1:0] r_rdPtr;
   logic [AW-1:0] r_wrPtr;
   logic [3:0]    r_level;
   logic          w_doPop;
   logic          w_doPush;

   // A full queue can still take a push when the head leaves in the same
   // cycle, because the freed slot is the one the write pointer targets.
   assign w_doPop  = i_pop && !o_empty;
   assign w_doPush = i_push && (!o_full || w_doPop);

   assign o_data  = r_mem[r_rdPtr];
   assign o_full  = (r_level == 4'(DEPTH));
   assign o_empty = (r_level == 4'd0);
   assign o_level = r_level;

   // Pointer and occupancy bookkeeping. DEPTH is a power of two, so the
   // pointers wrap naturally by overflowing their width.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_flush) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_level <= 4'd0;
      end else begin
         if (w_doPush) r_wrPtr <= r_wrPtr + AW'(1);
         if (w_doPop)  r_rdPtr <= r_rdPtr + AW'(1);
         case ({w_doPush, w_doPop})
            2'b10:   r_level <= r_level + 4'd1;
            2'b01:   r_level <= r_level - 4'd1;
            default: r_level <= r_level;
         endcase
      end
   end

   // Entry storage needs no reset: an entry is only read after it is written.
   always_ff @(posedge i_clk) begin
      if (w_doPush && !i_flush) r_mem[r_wrPtr] <= i_data;
   end

endmodule

// File: rtl/move_scheduler.sv
// Turns button presses into move commands for the 2048 game core.
// Rising button edges are queued (one direction per cycle), then issued to
// the core one at a time with a valid/ready handshake and a completion pulse.
// Ports:
//   clk, rst            - clock and synchronous active-low reset
//   btn_up/down/left/right - synchronized button levels
//   core_ready          - core accepts a command this cycle
//   core_done           - one-cycle pulse when the core finishes a move
//   core_end            - core reached end of game, valid with core_done
//   cmd_valid, cmd_dir  - command request and direction (0 when idle)
//   move_cnt            - completed moves, saturating
//   q_level             - queue occupancy
//   overflow            - sticky: a press was dropped on a full queue
//   timeout_err         - sticky: the core did not finish in time
//   game_over           - scheduler halted at end of game
//   busy                - scheduler is not idle
module move_scheduler
   import game2048_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        core_ready,
   input  logic        core_done,
   input  logic        core_end,
   output logic        cmd_valid,
   output logic [2:0]  cmd_dir,
   output logic [15:0] move_cnt,
   output logic [3:0]  q_level,
   output logic        overflow,
   output logic        timeout_err,
   output logic        game_over,
   output logic        busy
);

   localparam int CW = $clog2(TIMEOUT + 1);

   sched_state_t r_state;
   sched_state_t w_nextState;
   logic [3:0]   r_btnPrev;
   logic [3:0]   w_btnNow;
   logic [3:0]   w_rise;
   logic [2:0]   w_pressDir;
   logic         w_pressAny;
   logic [CW-1:0] r_waitCnt;
   logic [15:0]  r_moveCnt;
   logic         r_overflow;
   logic         r_timeoutErr;
   logic [2:0]   w_head;
   logic         w_full;
   logic         w_empty;
   logic         w_pop;
   logic         w_push;
   logic         w_flush;
   logic         w_doneInWait;
   logic         w_timeout;

   // Edge detection against the previous levels; {up, down, left, right}.
   assign w_btnNow   = {btn_up, btn_down, btn_left, btn_right};
   assign w_rise     = w_btnNow & ~r_btnPrev;
   assign w_pressAny = |w_rise;
   assign w_pressDir = pickDir(w_rise);

   // Completion only counts while waiting; a stray pulse elsewhere is ignored.
   assign w_doneInWait = (r_state == ST_WAIT) && core_done;
   assign w_timeout    = (r_state == ST_WAIT) && !core_done &&
                         (r_waitCnt == CW'(TIMEOUT - 1));

   // The queue is emptied on the cycle the game ends and every cycle after,
   // so nothing left over can ever be issued again before reset.
   assign w_flush = (r_state == ST_HALT) || (w_doneInWait && core_end);
   assign w_pop   = (r_state == ST_ISSUE) && core_ready;
   assign w_push  = w_pressAny && !w_flush;

   move_fifo #(.DEPTH(DEPTH)) u_fifo (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (w_flush),
      .i_data  (w_pressDir),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (q_level)
   );

   // Next-state and command outputs. The command is driven only from the
   // state and the registered queue head, so it stays stable while the core
   // keeps core_ready low.
   always_comb begin
      w_nextState = r_state;
      cmd_valid   = 1'b0;
      cmd_dir     = DIR_NONE;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty) w_nextState = ST_ISSUE;
         end
         ST_ISSUE: begin
            cmd_valid = 1'b1;
            cmd_dir   = w_head;
            if (core_ready) w_nextState = ST_WAIT;
         end
         ST_WAIT: begin
            if (core_done)      w_nextState = core_end ? ST_HALT : ST_IDLE;
            else if (w_timeout) w_nextState = ST_IDLE;
         end
         ST_HALT: begin
            w_nextState = ST_HALT;
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   // State register, wait counter, move counter and sticky error flags.
   // Previous button levels reset high so a button already held when reset
   // is released does not look like a fresh press.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= ST_IDLE;
         r_btnPrev    <= 4'b1111;
         r_waitCnt    <= '0;
         r_moveCnt    <= 16'd0;
         r_overflow   <= 1'b0;
         r_timeoutErr <= 1'b0;
      end else begin
         r_state   <= w_nextState;
         r_btnPrev <= w_btnNow;
         if ((r_state == ST_WAIT) && (w_nextState == ST_WAIT))
            r_waitCnt <= r_waitCnt + CW'(1);
         else
            r_waitCnt <= '0;
         if (w_doneInWait && (r_moveCnt != 16'hFFFF))
            r_moveCnt <= r_moveCnt + 16'd1;
         if (w_push && w_full && !w_pop)
            r_overflow <= 1'b1;
         if (w_timeout)
            r_timeoutErr <= 1'b1;
      end
   end

   assign move_cnt    = r_moveCnt;
   assign overflow    = r_overflow;
   assign timeout_err = r_timeoutErr;
   assign game_over   = (r_state == ST_HALT);
   assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_move_scheduler.sv
module tb_move_scheduler;

   logic        clk;
   logic        rst;
   logic        btn_up;
   logic        btn_down;
   logic        btn_left;
   logic        btn_right;
   logic        core_ready;
   logic        core_done;
   logic        core_end;
   logic        cmd_valid;
   logic [2:0]  cmd_dir;
   logic [15:0] move_cnt;
   logic [3:0]  q_level;
   logic        overflow;
   logic        timeout_err;
   logic        game_over;
   logic        busy;

   int testsRun;
   int testsFailed;

   move_scheduler #(.DEPTH(4), .TIMEOUT(15)) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_up      (btn_up),
      .btn_down    (btn_down),
      .btn_left    (btn_left),
      .btn_right   (btn_right),
      .core_ready  (core_ready),
      .core_done   (core_done),
      .core_end    (core_end),
      .cmd_valid   (cmd_valid),
      .cmd_dir     (cmd_dir),
      .move_cnt    (move_cnt),
      .q_level     (q_level),
      .overflow    (overflow),
      .timeout_err (timeout_err),
      .game_over   (game_over),
      .busy        (busy)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one cycle; inputs are driven and outputs sampled 1 unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
      core_ready = 1'b0; core_done = 1'b0; core_end = 1'b0;
      tick(); tick();
      testsRun++;
      if ({cmd_valid, cmd_dir, q_level, overflow, timeout_err, game_over, busy} !== 13'd0) begin
         testsFailed++;
         $display("[TB] FAIL reset_flags: got valid=%0b dir=%0d lvl=%0d ovf=%0b to=%0b go=%0b busy=%0b expected all 0",
                  cmd_valid, cmd_dir, q_level, overflow, timeout_err, game_over, busy);
      end
      testsRun++;
      if (move_cnt !== 16'd0) begin
         testsFailed++;
         $display("[TB] FAIL reset_move_cnt: got %0d expected 0", move_cnt);
      end
      rst = 1'b1;
      tick(); tick();
   endtask

   task automatic test_single_press();
      btn_left = 1'b1; core_ready = 1'b1;
      tick();
      testsRun++;
      if (q_level !== 4'd1 || cmd_valid !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL single_enqueue: got lvl=%0d valid=%0b expected lvl=1 valid=0", q_level, cmd_valid);
      end
      tick();
      testsRun++;
      if (cmd_valid !== 1'b1 || cmd_dir !== 3'd3) begin
         testsFailed++;
         $display("[TB] FAIL single_issue: got valid=%0b dir=%0d expected valid=1 dir=3", cmd_valid, cmd_dir);
      end
      tick();
      testsRun++;
      if (cmd_valid !== 1'b0 || q_level !== 4'd0 || busy !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL single_wait: got valid=%0b lvl=%0d busy=%0b expected 0 0 1", cmd_valid, q_level, busy);
      end
      core_ready = 1'b0;
      tick(); tick();
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      testsRun++;
      if (move_cnt !== 16'd1 || busy !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL single_done: got cnt=%0d busy=%0b expected cnt=1 busy=0", move_cnt, busy);
      end
      btn_left = 1'b0;
      tick();
   endtask

   task automatic test_simultaneous();
      btn_down = 1'b1; btn_right = 1'b1;
      tick();
      testsRun++;
      if (q_level !== 4'd1) begin
         testsFailed++;
         $display("[TB] FAIL simul_level: got %0d expected 1", q_level);
      end
      tick();
      testsRun++;
      if (cmd_valid !== 1'b1 || cmd_dir !== 3'd2) begin
         testsFailed++;
         $display("[TB] FAIL simul_dir: got valid=%0b dir=%0d expected valid=1 dir=2", cmd_valid, cmd_dir);
      end
      core_ready = 1'b1;
      tick();
      core_ready = 1'b0;
      testsRun++;
      if (q_level !== 4'd0 || cmd_valid !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL simul_single_entry: got lvl=%0d valid=%0b expected lvl=0 valid=0", q_level, cmd_valid);
      end
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      testsRun++;
      if (move_cnt !== 16'd2 || busy !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL simul_done: got cnt=%0d busy=%0b expected cnt=2 busy=0", move_cnt, busy);
      end
      btn_down = 1'b0; btn_right = 1'b0;
      tick();
   endtask

   task automatic test_overflow();
      core_ready = 1'b0;
      btn_up = 1'b1;    tick();
      btn_down = 1'b1;  tick();
      btn_left = 1'b1;  tick();
      btn_right = 1'b1; tick();
      testsRun++;
      if (q_level !== 4'd4 || overflow !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL ovf_full: got lvl=%0d ovf=%0b expected lvl=4 ovf=0", q_level, overflow);
      end
      btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
      tick();
      btn_up = 1'b1;
      tick();
      testsRun++;
      if (q_level !== 4'd4 || overflow !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL ovf_drop: got lvl=%0d ovf=%0b expected lvl=4 ovf=1", q_level, overflow);
      end
      testsRun++;
      if (cmd_valid !== 1'b1 || cmd_dir !== 3'd1) begin
         testsFailed++;
         $display("[TB] FAIL ovf_head: got valid=%0b dir=%0d expected valid=1 dir=1", cmd_valid, cmd_dir);
      end
   endtask

   task automatic test_timeout();
      core_ready = 1'b1;
      tick();
      core_ready = 1'b0;
      testsRun++;
      if (q_level !== 4'd3 || cmd_valid !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL to_pop: got lvl=%0d valid=%0b expected lvl=3 valid=0", q_level, cmd_valid);
      end
      for (int i = 0; i < 14; i++) tick();
      testsRun++;
      if (timeout_err !== 1'b0 || busy !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL to_early: got to=%0b busy=%0b expected to=0 busy=1", timeout_err, busy);
      end
      tick();
      testsRun++;
      if (timeout_err !== 1'b1 || busy !== 1'b0 || move_cnt !== 16'd2) begin
         testsFailed++;
         $display("[TB] FAIL to_fire: got to=%0b busy=%0b cnt=%0d expected to=1 busy=0 cnt=2",
                  timeout_err, busy, move_cnt);
      end
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      testsRun++;
      if (move_cnt !== 16'd2) begin
         testsFailed++;
         $display("[TB] FAIL done_outside_wait: got cnt=%0d expected 2", move_cnt);
      end
      testsRun++;
      if (cmd_valid !== 1'b1 || cmd_dir !== 3'd2) begin
         testsFailed++;
         $display("[TB] FAIL to_next_issue: got valid=%0b dir=%0d expected valid=1 dir=2", cmd_valid, cmd_dir);
      end
   endtask

   task automatic test_end_of_game();
      core_ready = 1'b1;
      tick();
      core_ready = 1'b0;
      testsRun++;
      if (q_level !== 4'd2) begin
         testsFailed++;
         $display("[TB] FAIL end_queued: got %0d expected 2", q_level);
      end
      core_done = 1'b1; core_end = 1'b1;
      tick();
      core_done = 1'b0; core_end = 1'b0;
      testsRun++;
      if (game_over !== 1'b1 || q_level !== 4'd0 || move_cnt !== 16'd3 || cmd_valid !== 1'b0 || cmd_dir !== 3'd0) begin
         testsFailed++;
         $display("[TB] FAIL end_halt: got go=%0b lvl=%0d cnt=%0d valid=%0b dir=%0d expected 1 0 3 0 0",
                  game_over, q_level, move_cnt, cmd_valid, cmd_dir);
      end
      btn_up = 1'b0;
      tick();
      btn_up = 1'b1; btn_left = 1'b1; core_ready = 1'b1;
      tick();
      testsRun++;
      if (q_level !== 4'd0 || game_over !== 1'b1 || busy !== 1'b1 || cmd_valid !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL end_ignore: got lvl=%0d go=%0b busy=%0b valid=%0b expected 0 1 1 0",
                  q_level, game_over, busy, cmd_valid);
      end
      core_ready = 1'b0; btn_left = 1'b0;
   endtask

   task automatic test_reset_held_button();
      rst = 1'b0;
      tick(); tick();
      testsRun++;
      if ({game_over, overflow, timeout_err, busy, cmd_valid} !== 5'd0 || move_cnt !== 16'd0 || q_level !== 4'd0) begin
         testsFailed++;
         $display("[TB] FAIL rst_clear: got go=%0b ovf=%0b to=%0b busy=%0b valid=%0b cnt=%0d lvl=%0d expected all 0",
                  game_over, overflow, timeout_err, busy, cmd_valid, move_cnt, q_level);
      end
      rst = 1'b1;
      tick(); tick(); tick();
      testsRun++;
      if (q_level !== 4'd0 || busy !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL held_no_press: got lvl=%0d busy=%0b expected 0 0", q_level, busy);
      end
      btn_up = 1'b0; btn_right = 1'b1;
      tick();
      testsRun++;
      if (q_level !== 4'd1) begin
         testsFailed++;
         $display("[TB] FAIL post_rst_press: got lvl=%0d expected 1", q_level);
      end
      tick();
      testsRun++;
      if (cmd_valid !== 1'b1 || cmd_dir !== 3'd4) begin
         testsFailed++;
         $display("[TB] FAIL post_rst_issue: got valid=%0b dir=%0d expected valid=1 dir=4", cmd_valid, cmd_dir);
      end
   endtask

   task automatic test_reset_mid_handshake();
      core_ready = 1'b1;
      tick();
      core_ready = 1'b0;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      testsRun++;
      if (busy !== 1'b0 || move_cnt !== 16'd0 || q_level !== 4'd0 || cmd_valid !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL rst_mid: got busy=%0b cnt=%0d lvl=%0d valid=%0b expected 0 0 0 0",
                  busy, move_cnt, q_level, cmd_valid);
      end
   endtask

   // Scenarios run back to back; each one leaves the DUT in the state the
   // next one starts from.
   initial begin
      testsRun    = 0;
      testsFailed = 0;
      test_reset();
      test_single_press();
      test_simultaneous();
      test_overflow();
      test_timeout();
      test_end_of_game();
      test_reset_held_button();
      test_reset_mid_handshake();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
